mem_port_arbiter_32: RTL and testbench
======================================

// Module: mem_port_arbiter_32
// PURPOSE
//  Two-requester arbiter for one shared 32-bit memory port.
//  Requester A is instruction fetch; requester B is load/store.
//  Drives sel of the twoToOneMux_32 instances that steer address/data onto the port.
//  Latches the winning address; holds the port until the memory acknowledges.
// PARAMETERS
//  WIDTH    32  address/data width; must match the steered mux width
//  TIMEOUT  16  max BUSY cycles without memReady (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-high
//  reqA        in   1      requester A wants the port; held until doneA/timeoutErr
//  addrA       in   WIDTH  requester A address
//  reqB        in   1      requester B wants the port; held until doneB/timeoutErr
//  addrB       in   WIDTH  requester B address
//  memReady    in   1      memory accepted/completed the current access
//  sel         out  1      mux select: 0 = A path, 1 = B path
//  grantA      out  1      A owns the port
//  grantB      out  1      B owns the port
//  memValid    out  1      access presented on the port
//  memAddr     out  WIDTH  latched address of the granted requester
//  doneA       out  1      one-cycle completion pulse to A
//  doneB       out  1      one-cycle completion pulse to B
//  timeoutErr  out  1      one-cycle abort pulse; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  - All outputs are registered. Reset values: every output 0; state IDLE; lastGnt = B.
//  - rst is asynchronous and active-high. Asserting it mid-transaction forces the reset values immediately.
//  - FSM states: IDLE, BUSY_A, BUSY_B.
//  - IDLE, transitions at the next edge:
//    - only reqA: go to BUSY_A.
//    - only reqB: go to BUSY_B.
//    - both: grant the requester that is not lastGnt (round-robin).
//    - neither: stay in IDLE.
//  - Entering BUSY_x:
//    - grantX=1, memValid=1.
//    - sel=0 for A, 1 for B.
//    - memAddr = addrX, sampled at the same edge.
//    - lastGnt = x.
//    - Latency: req sampled at edge k, grant visible after edge k.
//  - BUSY_x: memAddr, sel and grant hold steady.
//    - Changes on addrX or reqX are ignored; deasserting reqX does not abort the access.
//  - memReady high at edge m while BUSY_x:
//    - grantX, memValid go to 0 after edge m.
//    - doneX=1 for exactly one cycle after edge m.
//    - State returns to IDLE.
//    - sel keeps its last value.
//    - Earliest next grant is at edge m+1, giving one IDLE cycle between accesses.
//  - memReady while IDLE is ignored.
//  - doneA and doneB are never high together. grantA and grantB are never high together.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - A $clog2(TIMEOUT)+1-bit counter clears on BUSY entry and increments each BUSY cycle.
//    - If the count reaches TIMEOUT with no memReady, the FSM aborts: grant=0, memValid=0, state IDLE.
//    - timeoutErr=1 for one cycle; no done pulse.
//    - lastGnt keeps the aborted requester, so the other side wins the next tie.
//    - memReady on the same edge as expiry wins: normal completion.
//  - ARB_TIMEOUT_EN undefined:
//    - No counter; BUSY holds indefinitely.
//    - timeoutErr is tied to 0; the TIMEOUT parameter is unused.
// TESTING
//  1. rst=1 mid-clock with reqA=reqB=1 -> all outputs 0 immediately; state IDLE after release.
//  2. reqA=1, addrA=0x00400000, memReady high 2 cycles after grant
//     -> grantA=1, sel=0, memAddr=0x00400000 for 3 cycles; doneA one-cycle pulse.
//  3. reqA=reqB=1 held; memReady one cycle after each grant
//     -> grants A,B,A,B alternate, separated by one IDLE cycle.
//  4. reqB=1, addrB=0x10010000; addrB changes to 0x10010004 while BUSY_B
//     -> memAddr stays 0x10010000 until doneB.
//  5. rst pulse during BUSY_B, then reqA=reqB=1 -> grantA first (lastGnt reset to B).
//  6. memReady held 0, TIMEOUT=16
//     -> with ARB_TIMEOUT_EN: grant drops and timeoutErr pulses after 16 BUSY cycles.
//     -> without it: grant is still held at cycle 100.

Source files
------------

// File: rtl/mem_port_arbiter_32.sv
// ============================================================================
// Module      : mem_port_arbiter_32
// Description : Round-robin arbiter giving instruction fetch (A) or load/store
//               (B) ownership of one shared memory port until memReady.
//               Optional busy-timeout abort enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter_32 #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqA,
    input  logic [WIDTH-1:0] addrA,
    input  logic             reqB,
    input  logic [WIDTH-1:0] addrB,
    input  logic             memReady,
    output logic             sel,
    output logic             grantA,
    output logic             grantB,
    output logic             memValid,
    output logic [WIDTH-1:0] memAddr,
    output logic             doneA,
    output logic             doneB,
    output logic             timeoutErr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_A = 2'd1;
    localparam logic [1:0] S_BUSY_B = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_b;
    logic             r_sel;
    logic             r_grant_a;
    logic             r_grant_b;
    logic             r_mem_valid;
    logic [WIDTH-1:0] r_mem_addr;
    logic             r_done_a;
    logic             r_done_b;

    logic w_busy;
    logic w_pick_a;
    logic w_pick_b;
    logic w_expire;

    assign w_busy   = (r_state == S_BUSY_A) || (r_state == S_BUSY_B);
    // On a tie, A wins only when B held the port last.
    assign w_pick_a = reqA && (!reqB || r_last_b);
    assign w_pick_b = reqB && !w_pick_a;

`ifdef ARB_TIMEOUT_EN
    localparam int               CW         = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]    c_tmo_last = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_busy_cnt;
    logic          r_timeout;

    // A same-edge memReady takes precedence over expiry.
    assign w_expire = w_busy && !memReady && (r_busy_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout  <= w_expire;
            r_busy_cnt <= w_busy ? r_busy_cnt + 1'b1 : '0;
        end
    end

    assign timeoutErr = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_expire         = 1'b0;
    assign timeoutErr       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_b    <= 1'b1;
            r_sel       <= 1'b0;
            r_grant_a   <= 1'b0;
            r_grant_b   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_done_a    <= 1'b0;
            r_done_b    <= 1'b0;
        end else begin
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_a) begin
                        r_state     <= S_BUSY_A;
                        r_last_b    <= 1'b0;
                        r_sel       <= 1'b0;
                        r_grant_a   <= 1'b1;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= addrA;
                    end else if (w_pick_b) begin
                        r_state     <= S_BUSY_B;
                        r_last_b    <= 1'b1;
                        r_sel       <= 1'b1;
                        r_grant_b   <= 1'b1;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= addrB;
                    end
                end
                S_BUSY_A, S_BUSY_B: begin
                    if (memReady || w_expire) begin
                        r_state     <= S_IDLE;
                        r_grant_a   <= 1'b0;
                        r_grant_b   <= 1'b0;
                        r_mem_valid <= 1'b0;
                        r_done_a    <= memReady && (r_state == S_BUSY_A);
                        r_done_b    <= memReady && (r_state == S_BUSY_B);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_grant_a   <= 1'b0;
                    r_grant_b   <= 1'b0;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sel      = r_sel;
    assign grantA   = r_grant_a;
    assign grantB   = r_grant_b;
    assign memValid = r_mem_valid;
    assign memAddr  = r_mem_addr;
    assign doneA    = r_done_a;
    assign doneB    = r_done_b;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter_32.sv
// ============================================================================
// Module      : tb_mem_port_arbiter_32
// Description : Self-checking bench for mem_port_arbiter_32 against a
//               transaction-level ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter_32;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             reqA, reqB, memReady;
    logic [WIDTH-1:0] addrA, addrB;
    logic             sel, grantA, grantB, memValid, doneA, doneB, timeoutErr;
    logic [WIDTH-1:0] memAddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_32 #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .reqA(reqA), .addrA(addrA), .reqB(reqB), .addrB(addrB),
        .memReady(memReady),
        .sel(sel), .grantA(grantA), .grantB(grantB), .memValid(memValid),
        .memAddr(memAddr), .doneA(doneA), .doneB(doneB), .timeoutErr(timeoutErr)
    );

    // Reference model: who owns the port (0 none, 1 A, 2 B) and how long.
    int               m_owner, m_last, m_busy;
    logic [WIDTH-1:0] m_addr;
    logic             m_sel, m_doneA, m_doneB, m_to;

    always @(posedge clk or posedge rst) begin : model
        int pick;
        if (rst) begin
            m_owner <= 0; m_last <= 2; m_busy <= 0; m_addr <= '0;
            m_sel <= 1'b0; m_doneA <= 1'b0; m_doneB <= 1'b0; m_to <= 1'b0;
        end else begin
            m_doneA <= 1'b0; m_doneB <= 1'b0; m_to <= 1'b0;
            if (m_owner == 0) begin
                pick = 0;
                if (reqA && reqB) pick = 3 - m_last;
                else if (reqA)    pick = 1;
                else if (reqB)    pick = 2;
                if (pick != 0) begin
                    m_owner <= pick;
                    m_last  <= pick;
                    m_addr  <= (pick == 1) ? addrA : addrB;
                    m_sel   <= (pick == 2);
                    m_busy  <= 1;
                end
            end else if (memReady) begin
                m_doneA <= (m_owner == 1);
                m_doneB <= (m_owner == 2);
                m_owner <= 0;
            end else begin
                m_busy <= m_busy + 1;
                if (TMO_ON && m_busy >= TIMEOUT) begin
                    m_to    <= 1'b1;
                    m_owner <= 0;
                end
            end
        end
    end

    logic [WIDTH+6:0] exp_vec, dut_vec;
    assign exp_vec = {m_sel, (m_owner == 1), (m_owner == 2), (m_owner != 0),
                      m_addr, m_doneA, m_doneB, m_to};
    assign dut_vec = {sel, grantA, grantB, memValid, memAddr, doneA, doneB, timeoutErr};

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; reqA = 1'b0; reqB = 1'b0; memReady = 1'b0;
        addrA = '0; addrB = '0;
        tick; tick;
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", dut_vec);
        end
        rst = 1'b0;
        reqA = 1'b1; reqB = 1'b1; addrA = 32'h0000_1000; addrB = 32'h0000_2000;
        tick;
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL reset_first_grant: got %h expected %h", dut_vec, exp_vec);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_async: got %h expected 0", dut_vec);
        end
        reqA = 1'b0; reqB = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_release: got %h expected 0", dut_vec);
        end
        @(negedge clk);
    endtask

    task automatic test_single_a;
        int gcnt = 0;
        bit saw_done = 0;
        reqA = 1'b1; addrA = 32'h0040_0000; reqB = 1'b0; memReady = 1'b0;
        tick;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL single_a_cycle%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            if (grantA) begin
                gcnt++;
                checks++;
                if (sel !== 1'b0 || memAddr !== 32'h0040_0000) begin
                    errors++; $display("FAIL single_a_port: sel %b addr %h expected 0 00400000", sel, memAddr);
                end
            end
            if (doneA) saw_done = 1;
            memReady = (gcnt == 3) && grantA;
            if (doneA) reqA = 1'b0;
            tick;
        end
        checks++;
        if (gcnt != 3 || !saw_done) begin
            errors++; $display("FAIL single_a_len: grant cycles %0d done %0d expected 3 1", gcnt, saw_done);
        end
        memReady = 1'b0;
    endtask

    task automatic test_round_robin;
        int seq[$];
        int prev = 0;
        reqA = 1'b1; reqB = 1'b1; addrA = 32'hA; addrB = 32'hB;
        for (int i = 0; i < 16; i++) begin
            tick;
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL rr_cycle%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            if (grantA) seq.push_back(1);
            if (grantB) seq.push_back(2);
            if (memValid && prev != 0) begin
                checks++;
                errors++; $display("FAIL rr_gap: grant in cycle %0d without idle gap", i);
            end
            prev = memValid ? 1 : 0;
            memReady = memValid;
        end
        for (int i = 1; i < seq.size(); i++) begin
            checks++;
            if (seq[i] == seq[i-1]) begin
                errors++; $display("FAIL rr_alternate: grant %0d repeats requester %0d", i, seq[i]);
            end
        end
        checks++;
        if (seq.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d grants expected 8", seq.size());
        end
        reqA = 1'b0; reqB = 1'b0; memReady = 1'b0;
        tick;
    endtask

    task automatic test_addr_hold;
        reqB = 1'b1; addrB = 32'h1001_0000; memReady = 1'b0;
        tick;
        addrB = 32'h1001_0004;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_vec !== exp_vec || memAddr !== 32'h1001_0000 || grantB !== 1'b1) begin
                errors++; $display("FAIL addr_hold%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            memReady = (i == 4);
            tick;
        end
        checks++;
        if (doneB !== 1'b1 || memAddr !== 32'h1001_0000 || dut_vec !== exp_vec) begin
            errors++; $display("FAIL addr_hold_done: doneB %b addr %h expected 1 10010000", doneB, memAddr);
        end
        reqB = 1'b0; memReady = 1'b0;
        tick;
    endtask

    task automatic test_reset_busy;
        for (int first = 1; first <= 2; first++) begin
            reqA = (first == 1); reqB = (first == 2);
            tick;
            #2 rst = 1'b1;
            #1;
            checks++;
            if (dut_vec !== '0) begin
                errors++; $display("FAIL reset_busy%0d: got %h expected 0", first, dut_vec);
            end
            rst = 1'b0;
            reqA = 1'b1; reqB = 1'b1;
            @(negedge clk);
            tick;
            checks++;
            if (grantA !== 1'b1 || grantB !== 1'b0 || dut_vec !== exp_vec) begin
                errors++; $display("FAIL reset_busy_rr%0d: grantA %b grantB %b expected 1 0", first, grantA, grantB);
            end
            reqA = 1'b0; reqB = 1'b0; memReady = 1'b1;
            tick;
            memReady = 1'b0;
            tick;
        end
    endtask

    task automatic test_timeout;
        int gcnt = 0;
        int tcnt = 0;
        reqA = 1'b1; addrA = 32'h0000_0040; memReady = 1'b0;
        tick;
        reqA = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL timeout_cycle%0d: got %h expected %h", c, dut_vec, exp_vec);
            end
            if (grantA) gcnt++;
            if (timeoutErr) tcnt++;
            if (c == 100 && !TMO_ON) begin
                checks++;
                if (grantA !== 1'b1) begin
                    errors++; $display("FAIL timeout_hold100: grantA %b expected 1", grantA);
                end
            end
            tick;
        end
        checks++;
        if (TMO_ON ? (gcnt != TIMEOUT || tcnt != 1) : (gcnt != 110 || tcnt != 0)) begin
            errors++; $display("FAIL timeout_len: grant cycles %0d pulses %0d", gcnt, tcnt);
        end
        memReady = 1'b1;
        tick;
        memReady = 1'b0;
        tick;
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            checks++;
            if ((doneA && doneB) || (grantA && grantB)) begin
                errors++; $display("FAIL random_exclusive%0d: done %b%b grant %b%b", i, doneA, doneB, grantA, grantB);
            end
            reqA = reqA ? !(doneA || timeoutErr) : ($urandom_range(0, 2) == 0);
            reqB = reqB ? !(doneB || timeoutErr) : ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) addrA = $urandom;
            if ($urandom_range(0, 3) == 0) addrB = $urandom;
            memReady = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick;
        end
        reqA = 1'b0; reqB = 1'b0; memReady = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset;
        test_single_a;
        test_round_robin;
        test_addr_hold;
        test_reset_busy;
        test_timeout;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
